// File: rtl/rocc_accum_unit_if.sv
// rocc_accum_unit_if: RoCC command/response bundle between core (master) and accelerator (slave).
interface rocc_accum_unit_if #(
    parameter int XLEN = 64
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [6:0]      cmd_funct;
    logic [4:0]      cmd_rd;
    logic            cmd_xd;
    logic [XLEN-1:0] cmd_rs1;
    logic [XLEN-1:0] cmd_rs2;
    logic            resp_ready;
    logic            resp_valid;
    logic [4:0]      resp_rd;
    logic [XLEN-1:0] resp_data;
    logic            busy;
    logic            interrupt;
    logic            exception;

    modport master (
        output cmd_valid, cmd_funct, cmd_rd, cmd_xd, cmd_rs1, cmd_rs2, resp_ready, exception,
        input  cmd_ready, resp_valid, resp_rd, resp_data, busy, interrupt
    );

    modport slave (
        input  cmd_valid, cmd_funct, cmd_rd, cmd_xd, cmd_rs1, cmd_rs2, resp_ready, exception,
        output cmd_ready, resp_valid, resp_rd, resp_data, busy, interrupt
    );
endinterface

// File: rtl/rocc_accum_unit.sv
// rocc_accum_unit: RoCC accelerator with ADD/SUB and a small bank of accumulators.
module rocc_accum_unit #(
    parameter int XLEN    = 64,
    parameter int NUM_ACC = 4,
    parameter int SAT     = 0
) (
    input logic              clk,
    input logic              reset,
    rocc_accum_unit_if.slave io
);
    localparam int IDXW   = $clog2(NUM_ACC);
    localparam bit SAT_EN = SAT != 0;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e          state_q, state_d;
    logic            cmd_ready_q;
    logic [6:0]      funct_q;
    logic [4:0]      rd_q;
    logic            xd_q;
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic [4:0]      resp_rd_q;
    logic [XLEN-1:0] resp_data_q;
    logic [XLEN-1:0] acc_q [NUM_ACC];
    logic [XLEN-1:0] acc_d [NUM_ACC];

    logic            accept, legal, do_exec;
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] acc_sel, add_r, sub_r, acc_r, result;
    logic [XLEN:0]   sum_w, diff_w, acc_sum_w;

    assign accept  = cmd_ready_q & io.cmd_valid;
    assign legal   = funct_q < 7'd6;
    assign do_exec = (state_q == EXEC) & legal;
    assign idx     = rs2_q[IDXW-1:0];
    assign acc_sel = acc_q[idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= state_d == IDLE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? EXEC : IDLE;
            EXEC:    state_d = (!io.exception && xd_q && legal) ? RESP : IDLE;
            RESP:    state_d = (io.exception || io.resp_ready) ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io.cmd_ready  = cmd_ready_q;
        io.resp_valid = state_q == RESP;
        io.resp_rd    = resp_rd_q;
        io.resp_data  = resp_data_q;
        io.busy       = state_q != IDLE;
        io.interrupt  = (state_q == EXEC) & ~legal;
    end

    // Carry/borrow kept in the extra MSB so saturation can clamp without a separate compare.
    always_comb begin
        sum_w     = {1'b0, rs1_q} + {1'b0, rs2_q};
        diff_w    = {1'b0, rs1_q} - {1'b0, rs2_q};
        acc_sum_w = {1'b0, acc_sel} + {1'b0, rs1_q};
        add_r     = (SAT_EN && sum_w[XLEN]) ? '1 : sum_w[XLEN-1:0];
        sub_r     = (SAT_EN && diff_w[XLEN]) ? '0 : diff_w[XLEN-1:0];
        acc_r     = (SAT_EN && acc_sum_w[XLEN]) ? '1 : acc_sum_w[XLEN-1:0];
        result    = funct_q == 7'd0 ? add_r :
                    funct_q == 7'd1 ? sub_r :
                    funct_q == 7'd2 ? acc_r :
                    (funct_q == 7'd3 || funct_q == 7'd4) ? acc_sel : '0;
    end

    always_comb begin
        for (int i = 0; i < NUM_ACC; i++) begin
            acc_d[i] = !do_exec ? acc_q[i] :
                       funct_q == 7'd5 ? '0 :
                       (idx == IDXW'(i) && funct_q == 7'd2) ? acc_r :
                       (idx == IDXW'(i) && funct_q == 7'd4) ? rs1_q : acc_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            funct_q     <= '0;
            rd_q        <= '0;
            xd_q        <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            resp_rd_q   <= '0;
            resp_data_q <= '0;
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
        end else begin
            if (accept) begin
                funct_q <= io.cmd_funct;
                rd_q    <= io.cmd_rd;
                xd_q    <= io.cmd_xd;
                rs1_q   <= io.cmd_rs1;
                rs2_q   <= io.cmd_rs2;
            end
            if (do_exec) begin
                resp_rd_q   <= rd_q;
                resp_data_q <= result;
            end
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= acc_d[i];
        end
    end
endmodule

// File: tb/tb_rocc_accum_unit.sv
// tb_rocc_accum_unit: directed checks of a wrapping and a saturating instance driven in lockstep.
module tb_rocc_accum_unit;
    localparam logic [63:0] ONES = '1;

    logic        clk, reset;
    logic        cmd_valid, cmd_xd, resp_ready, exception;
    logic [6:0]  cmd_funct;
    logic [4:0]  cmd_rd;
    logic [63:0] cmd_rs1, cmd_rs2;
    int          n_tests, n_fail;

    rocc_accum_unit_if #(.XLEN(64)) bus ();
    rocc_accum_unit_if #(.XLEN(64)) bus_s ();

    assign bus.cmd_valid    = cmd_valid;
    assign bus.cmd_funct    = cmd_funct;
    assign bus.cmd_rd       = cmd_rd;
    assign bus.cmd_xd       = cmd_xd;
    assign bus.cmd_rs1      = cmd_rs1;
    assign bus.cmd_rs2      = cmd_rs2;
    assign bus.resp_ready   = resp_ready;
    assign bus.exception    = exception;
    assign bus_s.cmd_valid  = cmd_valid;
    assign bus_s.cmd_funct  = cmd_funct;
    assign bus_s.cmd_rd     = cmd_rd;
    assign bus_s.cmd_xd     = cmd_xd;
    assign bus_s.cmd_rs1    = cmd_rs1;
    assign bus_s.cmd_rs2    = cmd_rs2;
    assign bus_s.resp_ready = resp_ready;
    assign bus_s.exception  = exception;

    rocc_accum_unit #(.XLEN(64), .NUM_ACC(4), .SAT(0)) dut   (.clk(clk), .reset(reset), .io(bus));
    rocc_accum_unit #(.XLEN(64), .NUM_ACC(4), .SAT(1)) dut_s (.clk(clk), .reset(reset), .io(bus_s));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ":valid_idle"}, 64'(bus.resp_valid), 64'd0);
        check({tag, ":busy_idle"}, 64'(bus.busy), 64'd0);
        check({tag, ":ready_idle"}, 64'(bus.cmd_ready), 64'd1);
        check({tag, ":irq_idle"}, 64'(bus.interrupt), 64'd0);
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic do_cmd(input string tag, input logic [6:0] f, input logic [4:0] r, input logic x,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input logic [63:0] exp_s, input int stall);
        logic has_resp;
        has_resp = x && (f < 7'd6);
        check({tag, ":ready"}, 64'(bus.cmd_ready), 64'd1);
        resp_ready = stall == 0;
        cmd_funct = f; cmd_rd = r; cmd_xd = x; cmd_rs1 = a; cmd_rs2 = b; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, ":busy_exec"}, 64'(bus.busy), 64'd1);
        check({tag, ":ready_exec"}, 64'(bus.cmd_ready), 64'd0);
        check({tag, ":valid_exec"}, 64'(bus.resp_valid), 64'd0);
        check({tag, ":irq_exec"}, 64'(bus.interrupt), 64'(f >= 7'd6));
        @(negedge clk);
        if (has_resp) begin
            check({tag, ":valid"}, 64'(bus.resp_valid), 64'd1);
            check({tag, ":data"}, bus.resp_data, exp);
            check({tag, ":data_sat"}, bus_s.resp_data, exp_s);
            check({tag, ":rd"}, 64'(bus.resp_rd), 64'(r));
            check({tag, ":busy_resp"}, 64'(bus.busy), 64'd1);
            for (int i = 1; i < stall; i++) begin
                @(negedge clk);
                check({tag, ":valid_hold"}, 64'(bus.resp_valid), 64'd1);
                check({tag, ":data_hold"}, bus.resp_data, exp);
                check({tag, ":rd_hold"}, 64'(bus.resp_rd), 64'(r));
                check({tag, ":ready_hold"}, 64'(bus.cmd_ready), 64'd0);
            end
            resp_ready = 1'b1;
            @(negedge clk);
        end
        check_idle(tag);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b0; cmd_valid = 1'b0; cmd_xd = 1'b0; resp_ready = 1'b1; exception = 1'b0;
        cmd_funct = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        #12;
        check("rst:ready", 64'(bus.cmd_ready), 64'd1);
        check("rst:valid", 64'(bus.resp_valid), 64'd0);
        check("rst:busy", 64'(bus.busy), 64'd0);
        check("rst:irq", 64'(bus.interrupt), 64'd0);
        check("rst:rd", 64'(bus.resp_rd), 64'd0);
        check("rst:data", bus.resp_data, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        do_cmd("add", 7'd0, 5'd3, 1'b1, 64'd5, 64'd7, 64'd12, 64'd12, 0);
        do_cmd("add_ovf", 7'd0, 5'd4, 1'b1, ONES, 64'd2, 64'd1, ONES, 0);
        do_cmd("sub_udf", 7'd1, 5'd5, 1'b1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 0);
        do_cmd("sub", 7'd1, 5'd6, 1'b1, 64'd20, 64'd5, 64'd15, 64'd15, 0);
        do_cmd("write1", 7'd4, 5'd1, 1'b1, 64'd10, 64'd1, 64'd0, 64'd0, 0);
        do_cmd("acc1", 7'd2, 5'd2, 1'b1, 64'd5, 64'd1, 64'd15, 64'd15, 0);
        do_cmd("read5", 7'd3, 5'd7, 1'b1, 64'd0, 64'd5, 64'd15, 64'd15, 0);
        do_cmd("stall", 7'd3, 5'd8, 1'b1, 64'd0, 64'd1, 64'd15, 64'd15, 4);
        do_cmd("illegal", 7'd9, 5'd9, 1'b1, 64'd100, 64'd1, 64'd0, 64'd0, 0);
        do_cmd("read_after_ill", 7'd3, 5'd10, 1'b1, 64'd0, 64'd1, 64'd15, 64'd15, 0);
        do_cmd("acc_noxd", 7'd2, 5'd11, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0, 0);
        do_cmd("read_noxd", 7'd3, 5'd12, 1'b1, 64'd0, 64'd1, 64'd16, 64'd16, 0);

        // Exception while a response is pending: response dropped, accumulator write kept.
        resp_ready = 1'b0;
        cmd_funct = 7'd2; cmd_rd = 5'd13; cmd_xd = 1'b1; cmd_rs1 = 64'd4; cmd_rs2 = 64'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("exc:valid_resp", 64'(bus.resp_valid), 64'd1);
        check("exc:data_resp", bus.resp_data, 64'd4);
        exception = 1'b1;
        @(negedge clk);
        exception = 1'b0;
        check_idle("exc");
        do_cmd("read_exc", 7'd3, 5'd14, 1'b1, 64'd0, 64'd2, 64'd4, 64'd4, 0);

        // Exception raised in IDLE must not block acceptance.
        exception = 1'b1;
        cmd_funct = 7'd0; cmd_rd = 5'd15; cmd_xd = 1'b1; cmd_rs1 = 64'd1; cmd_rs2 = 64'd1; cmd_valid = 1'b1;
        @(negedge clk);
        exception = 1'b0; cmd_valid = 1'b0;
        check("exc_idle:busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check("exc_idle:valid", 64'(bus.resp_valid), 64'd1);
        check("exc_idle:data", bus.resp_data, 64'd2);
        @(negedge clk);
        check_idle("exc_idle");

        do_cmd("write3", 7'd4, 5'd16, 1'b1, ONES, 64'd3, 64'd0, 64'd0, 0);
        do_cmd("acc3_ovf", 7'd2, 5'd17, 1'b1, 64'd2, 64'd3, 64'd1, ONES, 0);
        do_cmd("read3", 7'd3, 5'd18, 1'b1, 64'd0, 64'd3, 64'd1, ONES, 0);
        do_cmd("clear", 7'd5, 5'd19, 1'b1, 64'd0, 64'd0, 64'd0, 64'd0, 0);
        do_cmd("read_clr", 7'd3, 5'd20, 1'b1, 64'd0, 64'd1, 64'd0, 64'd0, 0);
        do_cmd("write0", 7'd4, 5'd5, 1'b1, 64'd7, 64'd0, 64'd0, 64'd0, 0);

        // Reset mid-EXEC: outputs return to reset values without waiting for a clock edge.
        cmd_funct = 7'd0; cmd_rd = 5'd21; cmd_xd = 1'b1; cmd_rs1 = 64'd8; cmd_rs2 = 64'd8; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_mid:busy_exec", 64'(bus.busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid:busy", 64'(bus.busy), 64'd0);
        check("rst_mid:ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_mid:valid", 64'(bus.resp_valid), 64'd0);
        check("rst_mid:rd", 64'(bus.resp_rd), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        do_cmd("read_rst", 7'd3, 5'd22, 1'b1, 64'd0, 64'd0, 64'd0, 64'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
